// File: rtl/hamming_pkg.sv
// Shared mode type and elaboration-time helpers for the SECDED pipeline.
package hamming_pkg;

  typedef enum logic {ENCODE = 1'b0, DECODE = 1'b1} mode_e;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic logic is_pow2(input int idx);
    return (idx > 0) && ((idx & (idx - 1)) == 0);
  endfunction

  // Hamming position that carries payload bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int k = 3; k < 64; k++) begin
      if (!is_pow2(k)) begin
        if (n == idx) pos = k;
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; synchronous clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED Hamming encoder/decoder with valid/ready flow control.
// S1 captures the word with its syndrome/parity, S2 corrects and extracts into the output registers.
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int    DATA_W = 8,
  parameter mode_e MODE   = ENCODE,
  parameter int    CNT_W  = 16,
  localparam int   P      = calc_p(DATA_W),
  localparam int   CW_W   = DATA_W + P + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW_W-1:0]  out_data,
  output logic             out_sec,
  output logic             out_ded,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  logic              s1_adv, s2_adv;
  logic              s1_vld_q;
  logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_ov_q, s1_ov_d;
  logic              out_vld_q;
  logic [CW_W-1:0]   out_dat_q, out_dat_d;
  logic              out_sec_q, out_sec_d, out_ded_q, out_ded_d;
  logic [CW_W-1:0]   place, enc_cw, corr_cw;
  logic [DATA_W-1:0] payload;
  logic              par, dec_sec, dec_ded;

  assign s2_adv   = !out_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = !reset && s1_adv;

  // Each parity bit covers the positions whose index has its bit set.
  always_comb begin
    place = '0;
    for (int i = 0; i < DATA_W; i++) place[data_pos(i)] = in_data[i];
    enc_cw = place;
    for (int j = 0; j < P; j++) begin
      par = 1'b0;
      for (int k = 1; k < CW_W; k++) begin
        if (((k >> j) & 1) == 1) par = par ^ place[k];
      end
      enc_cw[1 << j] = par;
    end
    enc_cw[0] = ^enc_cw[CW_W-1:1];
  end

  always_comb begin
    s1_syn_d = '0;
    for (int k = 1; k < CW_W; k++) begin
      if (in_data[k]) s1_syn_d = s1_syn_d ^ P'(k);
    end
    s1_ov_d = ^in_data;
    s1_cw_d = (MODE == DECODE) ? in_data : enc_cw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_cw_q  <= '0;
      s1_syn_q <= '0;
      s1_ov_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_cw_q  <= s1_cw_d;
        s1_syn_q <= s1_syn_d;
        s1_ov_q  <= s1_ov_d;
      end
    end
  end

  // A syndrome beyond the last position with odd overall parity means 3+ errors.
  always_comb begin
    corr_cw = s1_cw_q;
    dec_sec = 1'b0;
    dec_ded = 1'b0;
    if (s1_syn_q == '0) begin
      dec_sec = s1_ov_q;
    end else if (!s1_ov_q || (int'(s1_syn_q) > CW_W - 1)) begin
      dec_ded = 1'b1;
    end else begin
      corr_cw[s1_syn_q] = ~s1_cw_q[s1_syn_q];
      dec_sec = 1'b1;
    end
    payload = '0;
    for (int i = 0; i < DATA_W; i++) payload[i] = corr_cw[data_pos(i)];
    out_dat_d = (MODE == DECODE) ? CW_W'(payload) : s1_cw_q;
    out_sec_d = (MODE == DECODE) && dec_sec;
    out_ded_d = (MODE == DECODE) && dec_ded;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_sec_q <= 1'b0;
      out_ded_q <= 1'b0;
    end else if (s2_adv) begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_dat_q <= out_dat_d;
        out_sec_q <= out_sec_d;
        out_ded_q <= out_ded_d;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;

  sat_counter #(.W(CNT_W)) u_corr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_vld_q && out_ready && out_sec_q),
    .clr   (cnt_clr),
    .count (corr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_uncorr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_vld_q && out_ready && out_ded_q),
    .clr   (cnt_clr),
    .count (uncorr_cnt)
  );

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench: an ENCODE and a DECODE instance driven in lockstep, checked against a brute-force SECDED model.
module tb_hamming_secded_pipe;
  import hamming_pkg::*;

  localparam int DW = 8;
  localparam int P  = 4;
  localparam int CW = 13;
  localparam int CN = 4;
  localparam int CMAX = 15;

  typedef struct {
    logic [CW-1:0] e_dat;
    logic [CW-1:0] d_dat;
    logic          d_sec;
    logic          d_ded;
  } exp_t;

  logic clk;
  logic reset, in_valid, out_ready, cnt_clr;
  logic [CW-1:0] e_in, d_in, e_out, d_out;
  logic e_in_ready, d_in_ready, e_ov, d_ov, e_sec, e_ded, d_sec, d_ded;
  logic [CN-1:0] e_corr, e_unc, d_corr, d_unc;

  int vectors = 0;
  int miscompares = 0;
  int m_corr = 0;
  int m_unc = 0;
  logic stall = 1'b0;
  logic [28:0] held;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hamming_secded_pipe #(.DATA_W(DW), .MODE(ENCODE), .CNT_W(CN)) u_enc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready), .in_data(e_in),
    .out_valid(e_ov), .out_ready(out_ready), .out_data(e_out), .out_sec(e_sec), .out_ded(e_ded),
    .cnt_clr(cnt_clr), .corr_cnt(e_corr), .uncorr_cnt(e_unc));

  hamming_secded_pipe #(.DATA_W(DW), .MODE(DECODE), .CNT_W(CN)) u_dec (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(d_in),
    .out_valid(d_ov), .out_ready(out_ready), .out_data(d_out), .out_sec(d_sec), .out_ded(d_ded),
    .cnt_clr(cnt_clr), .corr_cnt(d_corr), .uncorr_cnt(d_unc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: payload sits at non-power-of-two positions; parity bits are the syndrome of the payload.
  function automatic logic [CW-1:0] m_enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int n, s;
    c = '0; n = 0; s = 0;
    for (int k = 1; k < CW; k++) begin
      if ((k & (k - 1)) != 0) begin
        c[k] = d[n];
        if (d[n]) s = s ^ k;
        n++;
      end
    end
    for (int j = 0; j < P; j++) c[1 << j] = s[j];
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [DW-1:0] m_ext(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int n;
    d = '0; n = 0;
    for (int k = 1; k < CW; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[n] = c[k];
        n++;
      end
    end
    return d;
  endfunction

  // Decoding by search: valid codeword, or one flip away from one, else uncorrectable.
  function automatic exp_t m_dec(input logic [CW-1:0] r);
    exp_t x;
    logic [CW-1:0] t;
    x.e_dat = '0; x.d_dat = CW'(m_ext(r)); x.d_sec = 1'b0; x.d_ded = 1'b0;
    if (m_enc(m_ext(r)) != r) begin
      x.d_ded = 1'b1;
      for (int k = 0; k < CW; k++) begin
        t = r;
        t[k] = ~t[k];
        if (x.d_ded && (m_enc(m_ext(t)) == t)) begin
          x.d_ded = 1'b0; x.d_sec = 1'b1; x.d_dat = CW'(m_ext(t));
        end
      end
    end
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      m_corr = 0; m_unc = 0; stall = 1'b0;
    end else begin
      chk("corr_cnt", 32'(d_corr), m_corr);
      chk("uncorr_cnt", 32'(d_unc), m_unc);
      chk("enc_cnt", {e_corr, e_unc}, 32'd0);
      chk("lockstep", {e_ov, e_in_ready}, {d_ov, d_in_ready});
      if (stall) chk("hold", {d_ov, d_out, d_sec, d_ded, e_out}, held);
      if (d_ov && out_ready) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL spurious_out: got data %h with nothing expected at %0t", d_out, $time);
        end else begin
          e = q.pop_front();
          chk("enc_out", {e_out, e_sec, e_ded}, {e.e_dat, 2'b00});
          chk("dec_out", {d_out, d_sec, d_ded}, {e.d_dat, e.d_sec, e.d_ded});
          if (e.d_sec && m_corr != CMAX) m_corr++;
          if (e.d_ded && m_unc != CMAX) m_unc++;
        end
      end
      if (cnt_clr) begin m_corr = 0; m_unc = 0; end
      stall = d_ov && !out_ready;
      held = {1'b1, d_out, d_sec, d_ded, e_out};
      if (in_valid && d_in_ready) begin
        e = m_dec(d_in);
        e.e_dat = m_enc(e_in[DW-1:0]);
        q.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input logic [DW-1:0] pay, input logic [CW-1:0] dword);
    int t;
    t = 0;
    in_valid = 1'b1;
    e_in = CW'($urandom);
    e_in[DW-1:0] = pay;
    d_in = dword;
    @(negedge clk);
    while (!d_in_ready && t < 50) begin t++; @(negedge clk); end
    if (t >= 50) chk("in_ready_timeout", 32'(d_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [DW-1:0] pay, input logic [CW-1:0] dword,
                          input logic [CW-1:0] xe, input logic [CW-1:0] xd,
                          input logic xs, input logic xded, input int xc, input int xu);
    send(pay, dword);
    @(negedge clk);
    chk("lat_early", 32'(d_ov), 32'd0);
    @(negedge clk);
    chk("lat_valid", {e_ov, d_ov}, 32'b11);
    chk("vec_enc", {e_out, e_sec, e_ded}, {xe, 2'b00});
    chk("vec_dec", {d_out, d_sec, d_ded}, {xd, xs, xded});
    @(negedge clk);
    chk("vec_cnt", {d_corr, d_unc}, {CN'(xc), CN'(xu)});
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pin;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; e_in = '0; d_in = '0;
    chk("pin_enc01", m_enc(8'h01), 32'h00F);
    chk("pin_encFF", m_enc(8'hFF), 32'h1EEE);
    pin = m_dec(13'h02F);
    chk("pin_dec02F", {pin.d_dat, pin.d_sec, pin.d_ded}, {13'h001, 2'b10});

    repeat (2) @(negedge clk);
    chk("rst_dec", {d_ov, d_out, d_sec, d_ded, d_corr, d_unc, d_in_ready}, 32'd0);
    chk("rst_enc", {e_ov, e_out, e_sec, e_ded, e_corr, e_unc, e_in_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {e_in_ready, d_in_ready}, 32'b11);
    @(posedge clk); #1;

    send_chk(8'h01, 13'h02F, 13'h00F, 13'h001, 1'b1, 1'b0, 1, 0);
    send_chk(8'h01, 13'h06F, 13'h00F, 13'h007, 1'b0, 1'b1, 1, 1);
    send_chk(8'h01, 13'h00E, 13'h00F, 13'h001, 1'b1, 1'b0, 2, 1);
    send_chk(8'hFF, 13'h1EEE, 13'h1EEE, 13'h0FF, 1'b0, 1'b0, 2, 1);
    send_chk(8'h01, 13'h11D, 13'h00F, 13'h001, 1'b0, 1'b1, 2, 2);
    send_chk(8'h00, 13'h000, 13'h000, 13'h000, 1'b0, 1'b0, 2, 2);

    // Two words in flight behind a stalled output, then reset.
    out_ready = 1'b0;
    send(8'h12, m_enc(8'h12));
    send(8'h34, m_enc(8'h34));
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_in_rst", {e_in_ready, d_in_ready}, 32'b00);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("flush_valid", {e_ov, d_ov}, 32'b00);
    chk("flush_rdy", {e_in_ready, d_in_ready}, 32'b11);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flushed_gone", {e_ov, d_ov}, 32'b00);
    end
    @(posedge clk); #1;

    // 100 back-to-back words, output stalled for cycles 10..14.
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [CW-1:0] err;
          err = '0;
          if (i % 4 == 1) err[i % 13] = 1'b1;
          if (i % 4 == 2) begin err[i % 13] = 1'b1; err[(i + 5) % 13] = 1'b1; end
          send(DW'(i * 37 + 5), m_enc(DW'(i * 37 + 5)) ^ err);
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = !(c >= 10 && c <= 14);
          if (c == 13) begin
            #1 chk("rdy_full_stall", 32'(d_in_ready), 32'd0);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("stream_drained", 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Drive the corrected count into saturation, then clear it on a live handshake.
    for (int i = 0; i < 18; i++) send(DW'(i), m_enc(DW'(i)) ^ 13'h008);
    repeat (4) @(negedge clk);
    chk("corr_sat", 32'(d_corr), 32'd15);
    @(posedge clk); #1;
    send(8'h5A, m_enc(8'h5A) ^ 13'h040);
    repeat (4) @(negedge clk);
    chk("corr_sat_hold", 32'(d_corr), 32'd15);
    @(posedge clk); #1;
    send(8'hA5, m_enc(8'hA5) ^ 13'h100);
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", 32'(d_corr), 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hamming_secded_pipe.md
HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per word (legal range 4..57).
REQ-002 SHALL have parameter MODE, default ENCODE, meaning a static select of ENCODE or DECODE.
REQ-003 SHALL have parameter CNT_W, default 16, meaning error-counter width.
REQ-004 SHALL derive localparams P = smallest integer with 2^P >= DATA_W+P+1 and CW_W = DATA_W+P+1; DATA_W=8 gives P=4, CW_W=13.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word offered.
- in_ready  out  1  input word accepted when in_valid and in_ready are both 1.
- in_data  in  CW_W  ENCODE: payload in [DATA_W-1:0], upper bits ignored; DECODE: received codeword.
- out_valid  out  1  output word offered.
- out_ready  in  1  downstream accepts.
- out_data  out  CW_W  ENCODE: codeword; DECODE: corrected payload in [DATA_W-1:0], upper bits 0.
- out_sec  out  1  single error corrected (DECODE only, else 0).
- out_ded  out  1  uncorrectable error (DECODE only, else 0).
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of words delivered with out_sec=1.
- uncorr_cnt  out  CNT_W  count of words delivered with out_ded=1.

Function
REQ-007 Codeword layout SHALL be: bit[0] = overall parity; bit[k], k=1..CW_W-1, = Hamming position k; parity bits at power-of-two positions; payload bits in ascending order at the remaining positions, lowest payload bit at the lowest position.
REQ-008 Parity at position 2^j SHALL equal the XOR of all payload positions whose index has bit j set; bit[0] SHALL make the XOR of all CW_W bits equal 0.
REQ-009 Decode SHALL compute syndrome s = XOR of the indices of all set bits in positions 1..CW_W-1, and ov = XOR of all CW_W bits.
REQ-010 s=0, ov=0: payload passed unchanged; sec=0, ded=0.
REQ-011 s=0, ov=1: error in bit[0]; payload unchanged; sec=1.
REQ-012 s!=0, ov=1, s<=CW_W-1: flip position s, then extract payload; sec=1.
REQ-013 s!=0, ov=1, s>CW_W-1: ded=1; payload passed uncorrected.
REQ-014 s!=0, ov=0: double error; ded=1; payload passed uncorrected.
REQ-015 Pipeline SHALL have two register stages: S1 = input capture plus syndrome/parity, S2 = correction/extract plus output registers; latency is exactly 2 cycles from input handshake to out_valid with no stalls.
REQ-016 Throughput SHALL be one word per cycle while out_ready=1; no bubbles are inserted.
REQ-017 A stage SHALL advance when it is empty or the stage ahead advances; in_ready = !S1_valid or S1 advances, and SHALL NOT depend combinationally on in_valid.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_sec and out_ded SHALL hold stable; no word is dropped or duplicated.
REQ-019 Counters SHALL increment only on the output handshake; they saturate at 2^CNT_W-1 with no wrap.
REQ-020 cnt_clr with a simultaneous increment: the clear wins and the counter becomes 0.

Reset
REQ-021 Reset SHALL drive out_valid=0, out_data=0, out_sec=0, out_ded=0, corr_cnt=0, uncorr_cnt=0, and both stage-valid bits to 0.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight words; in_ready=0 while reset=1; in_ready=1 in the first cycle after release.

Structure
REQ-023 Package hamming_pkg SHALL hold the mode enum (ENCODE, DECODE), the functions calc_p(DATA_W) and is_pow2(idx), and the position-map function.
REQ-024 Counters SHALL be implemented as sub-module sat_counter (parameter W; ports clk, reset, inc, clr, count), instantiated twice.

Verification
REQ-025 ENCODE, DATA_W=8, in_data=0x001 -> after 2 cycles out_data=0x00F, sec=0, ded=0.
REQ-026 DECODE, in_data=0x02F (bit5 flipped) -> out_data=0x001, out_sec=1, corr_cnt=1.
REQ-027 DECODE, in_data=0x06F (bits 5 and 6 flipped) -> out_ded=1, uncorr_cnt=1; in_data=0x00E (bit0 flipped) -> out_data=0x001, out_sec=1.
REQ-028 Back-to-back 100 words with out_ready held 0 for cycles 10..14 -> in-order, lossless delivery; out_data stable while stalled; in_ready=0 after both stages fill.
REQ-029 corr_cnt preset to 0xFFFF by forcing errors, plus one more error -> stays 0xFFFF; cnt_clr coincident with an error handshake -> 0.
REQ-030 Reset pulsed with 2 words in flight -> out_valid=0 next cycle; neither word appears at the output; in_ready=1 after release.
